// File: rtl/fetch_stage_if.sv
// Instruction-memory channel between the fetch stage and the instruction memory.
//   req_valid / req_addr / req_ready : word request, fires on valid & ready
//   rsp_valid / rsp_data             : single-cycle, in-order response, one per fired request
// master = fetch stage side, slave = memory side.
interface fetch_stage_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage RV32I pipeline.
// Owns the fetch PC, issues one word request at a time to instruction memory,
// and loads the IF/ID register from responses (via a 1-entry hold buffer while
// decode is stalled). EX redirects squash IF/ID and any in-flight fetch.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   imem            : instruction-memory request/response channel (master)
//   redirect_valid  : EX redirect (branch/JAL/JALR taken)
//   redirect_pc     : redirect target, bits [1:0] ignored
//   stall           : freeze IF/ID
//   id_pc/id_instr/id_valid : IF/ID pipeline register
//
// state  | meaning
// S_REQ  | no request outstanding; request fetch_pc when hold buffer is empty
// S_WAIT | one request outstanding; its response is delivered
// S_DROP | one request outstanding but squashed; its response is discarded
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_stage_if.master        imem,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  input  logic                 stall,
  output logic [31:0]          id_pc,
  output logic [31:0]          id_instr,
  output logic                 id_valid
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_e;

  state_e      state_q;
  logic [31:0] fetch_pc_q;
  logic [31:0] req_pc_q;
  logic        hold_valid_q;
  logic [31:0] hold_pc_q;
  logic [31:0] hold_instr_q;
  logic        id_valid_q;
  logic [31:0] id_pc_q;
  logic [31:0] id_instr_q;

  logic        req_fire;
  logic        rsp_deliver;

  // No request while the hold buffer is full: that guarantees a response can
  // never arrive in the same cycle the hold buffer drains.
  assign imem.req_valid = (state_q == S_REQ) & ~hold_valid_q & ~redirect_valid & ~rst;
  assign imem.req_addr  = fetch_pc_q;

  assign req_fire    = imem.req_valid & imem.req_ready;
  assign rsp_deliver = (state_q == S_WAIT) & imem.rsp_valid;

  assign id_pc    = id_pc_q;
  assign id_instr = id_instr_q;
  assign id_valid = id_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= 32'h0;
      hold_valid_q <= 1'b0;
      hold_pc_q    <= 32'h0;
      hold_instr_q <= NOP_INSTR;
      id_valid_q   <= 1'b0;
      id_pc_q      <= 32'h0;
      id_instr_q   <= NOP_INSTR;
    end else if (redirect_valid) begin
      fetch_pc_q   <= {redirect_pc[31:2], 2'b00};
      id_valid_q   <= 1'b0;
      id_instr_q   <= NOP_INSTR;
      hold_valid_q <= 1'b0;
      // An outstanding request whose response is not here yet must be drained.
      case (state_q)
        S_WAIT:  state_q <= imem.rsp_valid ? S_REQ : S_DROP;
        S_DROP:  state_q <= imem.rsp_valid ? S_REQ : S_DROP;
        default: state_q <= S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_fire) begin
            req_pc_q   <= fetch_pc_q;
            fetch_pc_q <= fetch_pc_q + 32'd4;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.rsp_valid) state_q <= S_REQ;
        end
        S_DROP: begin
          if (imem.rsp_valid) state_q <= S_REQ;
        end
        default: state_q <= S_REQ;
      endcase

      if (!stall) begin
        if (hold_valid_q) begin
          id_valid_q   <= 1'b1;
          id_pc_q      <= hold_pc_q;
          id_instr_q   <= hold_instr_q;
          hold_valid_q <= 1'b0;
        end else if (rsp_deliver) begin
          id_valid_q <= 1'b1;
          id_pc_q    <= req_pc_q;
          id_instr_q <= imem.rsp_data;
        end else begin
          id_valid_q <= 1'b0;
          id_instr_q <= NOP_INSTR;
        end
      end else if (rsp_deliver) begin
        hold_valid_q <= 1'b1;
        hold_pc_q    <= req_pc_q;
        hold_instr_q <= imem.rsp_data;
      end
    end
  end

endmodule
